// File: rtl/vector_feeder.sv
// Vector display command feeder: buffers {pen, last, x, y} words and sequences
// them into a line generator, handling beam blanking and post-move settle time.
module vector_feeder #(
    parameter int BITS  = 16,
    parameter int DEPTH = 16,
    parameter int DWELL = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [BITS-1:0]          cmd_x,
    input  logic [BITS-1:0]          cmd_y,
    input  logic                     cmd_pen,
    input  logic                     cmd_last,
    input  logic                     pause,
    output logic                     line_strobe,
    output logic [BITS-1:0]          line_x,
    output logic [BITS-1:0]          line_y,
    input  logic                     line_ready,
    output logic                     blank,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    // state    | meaning
    // S_IDLE   | waiting for a queued word, pause=0 and line_ready=1
    // S_SETTLE | one cycle for the generator to register its new destination
    // S_WAIT   | segment in progress, waiting for line_ready
    // S_DWELL  | beam held blank while the deflection settles after a move
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT, S_DWELL} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DWELL + 1);
    localparam int WW = 2 * BITS + 2;
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL);

    logic [WW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            push;
    logic            pop;
    logic [WW-1:0]   head;

    state_t          state_q;
    logic            strobe_q;
    logic [BITS-1:0] x_q;
    logic [BITS-1:0] y_q;
    logic            blank_q;
    logic            frame_done_q;
    logic            pen_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q;

    assign cmd_ready = (count_q != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0) && !pause && line_ready;
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_pen, cmd_last, cmd_x, cmd_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            strobe_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            blank_q      <= 1'b1;
            frame_done_q <= 1'b0;
            pen_q        <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            strobe_q     <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // blank is left alone on entry so back-to-back draws stay lit
                    if (pop) begin
                        x_q      <= head[2*BITS-1:BITS];
                        y_q      <= head[BITS-1:0];
                        pen_q    <= head[WW-1];
                        last_q   <= head[WW-2];
                        blank_q  <= !head[WW-1];
                        strobe_q <= 1'b1;
                        state_q  <= S_SETTLE;
                    end else begin
                        blank_q  <= 1'b1;
                    end
                end
                S_SETTLE: state_q <= S_WAIT;
                S_WAIT: begin
                    if (line_ready) begin
                        frame_done_q <= last_q;
                        if (!pen_q) begin
                            cnt_q   <= DWELL_LD;
                            state_q <= S_DWELL;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_DWELL: begin
                    blank_q <= 1'b1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign line_strobe = strobe_q;
    assign line_x      = x_q;
    assign line_y      = y_q;
    assign blank       = blank_q;
    assign frame_done  = frame_done_q;
    assign fifo_level  = count_q;

endmodule

// File: tb/tb_vector_feeder.sv
// Directed bench for vector_feeder; inputs driven and outputs sampled on the
// falling edge, expected cycle positions worked out by hand per scenario.
module tb_vector_feeder;
    localparam int BITS  = 16;
    localparam int DEPTH = 16;
    localparam int DWELL = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [BITS-1:0] cmd_x;
    logic [BITS-1:0] cmd_y;
    logic            cmd_pen;
    logic            cmd_last;
    logic            pause;
    logic            line_strobe;
    logic [BITS-1:0] line_x;
    logic [BITS-1:0] line_y;
    logic            line_ready;
    logic            blank;
    logic            frame_done;
    logic [4:0]      fifo_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vector_feeder #(.BITS(BITS), .DEPTH(DEPTH), .DWELL(DWELL)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_pen(cmd_pen), .cmd_last(cmd_last),
        .pause(pause),
        .line_strobe(line_strobe), .line_x(line_x), .line_y(line_y),
        .line_ready(line_ready), .blank(blank), .frame_done(frame_done),
        .fifo_level(fifo_level)
    );

    task automatic drive_word(input int x, input int y, input logic pen, input logic last);
        cmd_valid = 1'b1;
        cmd_x     = BITS'(x);
        cmd_y     = BITS'(y);
        cmd_pen   = pen;
        cmd_last  = last;
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0;
        cmd_pen = 1'b0; cmd_last = 1'b0; pause = 1'b0; line_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        total++; if (line_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", line_strobe); end
        total++; if (line_x !== 16'd0 || line_y !== 16'd0) begin bad++; $display("FAIL reset_xy: got %0d,%0d want 0,0", line_x, line_y); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL reset_blank: got %b want 1", blank); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    endtask

    task automatic test_single;
        int errs;
        line_ready = 1'b1;
        drive_word(100, 200, 1'b1, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total++; if (line_strobe !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", line_strobe); end
        total++; if (line_x !== 16'd100 || line_y !== 16'd200) begin bad++; $display("FAIL single_xy: got %0d,%0d want 100,200", line_x, line_y); end
        total++; if (blank !== 1'b0) begin bad++; $display("FAIL single_blank: got %b want 0", blank); end
        line_ready = 1'b0;
        @(negedge clk);
        total++; if (line_strobe !== 1'b0) begin bad++; $display("FAIL single_strobe_width: got %b want 0", line_strobe); end
        errs = 0;
        for (int i = 0; i < 49; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || line_strobe !== 1'b0 || blank !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL single_hold: got %0d bad cycles want 0", errs); end
        line_ready = 1'b1;
        @(negedge clk);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL single_frame_done: got %b want 1", frame_done); end
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL single_frame_done_width: got %b want 0", frame_done); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL single_idle_blank: got %b want 1", blank); end
    endtask

    task automatic test_dwell;
        int errs;
        line_ready = 1'b1;
        drive_word(10, 10, 1'b0, 1'b0);
        @(negedge clk);
        drive_word(20, 10, 1'b1, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (line_strobe !== 1'b1 || line_x !== 16'd10) begin bad++; $display("FAIL move_strobe: got %b x=%0d want 1 x=10", line_strobe, line_x); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL move_blank: got %b want 1", blank); end
        line_ready = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (blank !== 1'b1 || line_strobe !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL move_travel: got %0d bad cycles want 0", errs); end
        line_ready = 1'b1;
        errs = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i < 10) begin
                if (blank !== 1'b1 || line_strobe !== 1'b0) errs++;
            end else begin
                total++; if (line_strobe !== 1'b1 || line_x !== 16'd20) begin bad++; $display("FAIL dwell_next_strobe: got %b x=%0d want 1 x=20", line_strobe, line_x); end
                total++; if (blank !== 1'b0) begin bad++; $display("FAIL dwell_draw_blank: got %b want 0", blank); end
            end
        end
        total++; if (errs != 0) begin bad++; $display("FAIL dwell_window: got %0d bad cycles want 0", errs); end
        line_ready = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (blank !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL draw_lit: got %0d bad cycles want 0", errs); end
        line_ready = 1'b1;
        @(negedge clk);
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL draw_no_frame_done: got %b want 0", frame_done); end
        @(negedge clk);
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL draw_idle_blank: got %b want 1", blank); end
    endtask

    task automatic test_full;
        int idx;
        line_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            total++; if (cmd_ready !== (k < 16)) begin bad++; $display("FAIL full_ready[%0d]: got %b want %b", k, cmd_ready, (k < 16)); end
            total++; if (fifo_level !== 5'((k < 16) ? k : 16)) begin bad++; $display("FAIL full_level[%0d]: got %0d want %0d", k, fifo_level, (k < 16) ? k : 16); end
            drive_word((k < 16) ? k : 16, 1000 + ((k < 16) ? k : 16), 1'b1, 1'b0);
            @(negedge clk);
        end
        total++; if (fifo_level !== 5'd16 || cmd_ready !== 1'b0) begin bad++; $display("FAIL full_hold: got level=%0d ready=%b want 16,0", fifo_level, cmd_ready); end
        line_ready = 1'b1;
        @(negedge clk);
        total++; if (fifo_level !== 5'd15 || cmd_ready !== 1'b1) begin bad++; $display("FAIL full_pop: got level=%0d ready=%b want 15,1", fifo_level, cmd_ready); end
        total++; if (line_strobe !== 1'b1 || line_x !== 16'd0 || line_y !== 16'd1000) begin bad++; $display("FAIL full_first: got %b x=%0d y=%0d want 1 x=0 y=1000", line_strobe, line_x, line_y); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (fifo_level !== 5'd16 || cmd_ready !== 1'b0) begin bad++; $display("FAIL full_refill: got level=%0d ready=%b want 16,0", fifo_level, cmd_ready); end
        idx = 1;
        for (int n = 0; n < 300 && idx < 17; n++) begin
            @(negedge clk);
            if (line_strobe === 1'b1) begin
                total++; if (line_x !== BITS'(idx)) begin bad++; $display("FAIL full_order[%0d]: got %0d want %0d", idx, line_x, idx); end
                idx++;
            end
        end
        total++; if (idx != 17) begin bad++; $display("FAIL full_drain: got %0d strobes want 17", idx); end
        repeat (4) @(negedge clk);
        total++; if (fifo_level !== 5'd0 || blank !== 1'b1) begin bad++; $display("FAIL full_empty: got level=%0d blank=%b want 0,1", fifo_level, blank); end
    endtask

    task automatic test_back_to_back;
        logic exp_s, exp_b, exp_fd;
        line_ready = 1'b1;
        drive_word(1, 5, 1'b1, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_s  = (c == 2 || c == 5 || c == 8);
            exp_b  = !(c >= 2 && c <= 10);
            exp_fd = (c == 10);
            total++; if (line_strobe !== exp_s) begin bad++; $display("FAIL b2b_strobe[%0d]: got %b want %b", c, line_strobe, exp_s); end
            total++; if (blank !== exp_b) begin bad++; $display("FAIL b2b_blank[%0d]: got %b want %b", c, blank, exp_b); end
            total++; if (frame_done !== exp_fd) begin bad++; $display("FAIL b2b_frame_done[%0d]: got %b want %b", c, frame_done, exp_fd); end
            if (exp_s) begin
                total++; if (line_x !== BITS'(c / 3 + 1)) begin bad++; $display("FAIL b2b_x[%0d]: got %0d want %0d", c, line_x, c / 3 + 1); end
            end
            if (c == 1) drive_word(2, 5, 1'b1, 1'b0);
            if (c == 2) drive_word(3, 5, 1'b1, 1'b1);
            if (c == 3) cmd_valid = 1'b0;
        end
    endtask

    task automatic test_pause;
        logic exp_s, exp_b;
        line_ready = 1'b1;
        drive_word(50, 7, 1'b1, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            exp_s = (c == 2 || c == 13);
            exp_b = !((c >= 2 && c <= 6) || (c >= 13 && c <= 15));
            total++; if (line_strobe !== exp_s) begin bad++; $display("FAIL pause_strobe[%0d]: got %b want %b", c, line_strobe, exp_s); end
            total++; if (blank !== exp_b) begin bad++; $display("FAIL pause_blank[%0d]: got %b want %b", c, blank, exp_b); end
            if (c == 2 || c == 10) begin
                total++; if (line_x !== 16'd50) begin bad++; $display("FAIL pause_x1[%0d]: got %0d want 50", c, line_x); end
            end
            if (c == 13) begin
                total++; if (line_x !== 16'd60) begin bad++; $display("FAIL pause_x2: got %0d want 60", line_x); end
            end
            if (c == 12) begin
                total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL pause_level: got %0d want 1", fifo_level); end
            end
            if (c == 1) drive_word(60, 7, 1'b1, 1'b0);
            if (c == 2) begin cmd_valid = 1'b0; line_ready = 1'b0; end
            if (c == 3) pause = 1'b1;
            if (c == 5) line_ready = 1'b1;
            if (c == 12) pause = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        int errs;
        line_ready = 1'b1;
        drive_word(30, 30, 1'b1, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) drive_word(31, 30, 1'b1, 1'b0);
            if (c == 2) begin line_ready = 1'b0; drive_word(32, 30, 1'b1, 1'b0); end
            if (c == 3) drive_word(33, 30, 1'b1, 1'b0);
            if (c == 4) drive_word(34, 30, 1'b1, 1'b0);
            if (c == 5) begin
                cmd_valid = 1'b0;
                total++; if (fifo_level !== 5'd4) begin bad++; $display("FAIL rstmid_queued: got %0d want 4", fifo_level); end
            end
            if (c == 6) begin reset = 1'b1; line_ready = 1'b1; end
        end
        @(negedge clk);
        reset = 1'b0;
        total++; if (fifo_level !== 5'd0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_level: got level=%0d ready=%b want 0,1", fifo_level, cmd_ready); end
        total++; if (blank !== 1'b1) begin bad++; $display("FAIL rstmid_blank: got %b want 1", blank); end
        total++; if (frame_done !== 1'b0 || line_strobe !== 1'b0) begin bad++; $display("FAIL rstmid_pulses: got fd=%b strobe=%b want 0,0", frame_done, line_strobe); end
        total++; if (line_x !== 16'd0) begin bad++; $display("FAIL rstmid_x: got %0d want 0", line_x); end
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (frame_done !== 1'b0 || line_strobe !== 1'b0 || blank !== 1'b1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d bad cycles want 0", errs); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_dwell;
        test_full;
        test_back_to_back;
        test_pause;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vector_feeder.md
VECTOR_FEEDER -- requirements
Module: vector_feeder

Interface
REQ-001 SHALL have parameter BITS, default 16: coordinate width.
REQ-002 SHALL have parameter DEPTH, default 16: command FIFO entries; must be a power of 2, at least 2.
REQ-003 SHALL have parameter DWELL, default 8: blanked settle cycles after each pen-up move; at least 1.
REQ-004 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command word offered.
REQ-007 SHALL have port cmd_ready, output, 1: command FIFO can accept.
REQ-008 SHALL have port cmd_x, input, BITS: destination x.
REQ-009 SHALL have port cmd_y, input, BITS: destination y.
REQ-010 SHALL have port cmd_pen, input, 1: 1 = draw (beam on), 0 = move (beam off).
REQ-011 SHALL have port cmd_last, input, 1: final segment of a frame.
REQ-012 SHALL have port pause, input, 1: hold off new segments without aborting the current one.
REQ-013 SHALL have port line_strobe, output, 1: one-cycle load pulse to the line generator.
REQ-014 SHALL have port line_x, output, BITS: registered destination x to the line generator.
REQ-015 SHALL have port line_y, output, BITS: registered destination y to the line generator.
REQ-016 SHALL have port line_ready, input, 1: line generator has reached its destination.
REQ-017 SHALL have port blank, output, 1: beam blanking, 1 = off.
REQ-018 SHALL have port frame_done, output, 1: one-cycle pulse when a cmd_last segment completes.
REQ-019 SHALL have port fifo_level, output, clog2(DEPTH)+1: occupied FIFO entries.

Function
REQ-020 SHALL store {pen, last, x, y} in a DEPTH-entry FIFO; a push SHALL occur on any edge with cmd_valid && cmd_ready.
REQ-021 SHALL drive cmd_ready = (fifo_level != DEPTH), derived from registered state only; a simultaneous pop SHALL NOT admit a push when full.
REQ-022 SHALL NOT bypass the FIFO: a word pushed into an empty FIFO SHALL be poppable on the next cycle; push and pop SHALL be allowed together, with the level unchanged.
REQ-023 SHALL implement FSM states IDLE, SETTLE, WAIT and DWELL.
REQ-024 IDLE: when the FIFO is non-empty, pause=0 and line_ready=1, the FSM SHALL pop the head and register line_x/line_y, pulse line_strobe high for exactly one cycle, set blank = !pen, latch pen/last, and go to SETTLE.
REQ-025 SETTLE: the FSM SHALL ignore line_ready for one cycle, covering the generator's registered destination update, then go to WAIT.
REQ-026 WAIT: when line_ready=1, the FSM SHALL pulse frame_done if the latched last=1; it SHALL go to DWELL if the latched pen=0, else to IDLE.
REQ-027 DWELL: the FSM SHALL hold blank=1 for DWELL cycles using a down-counter, then go to IDLE.
REQ-028 In IDLE with an empty FIFO or pause=1, blank SHALL be driven 1 from the next edge.
REQ-029 A pen-down segment SHALL keep blank=0 from its strobe through WAIT; back-to-back pen-down segments SHALL NOT glitch blank high.
REQ-030 Minimum spacing SHALL be 3 cycles between strobes for pen-down segments and DWELL+3 cycles for pen-up segments.
REQ-031 A zero-length segment (line_ready stays 1) SHALL still traverse SETTLE and WAIT and complete normally.
REQ-032 pause asserted in SETTLE, WAIT or DWELL SHALL NOT alter the current segment; it SHALL only block the next pop.
REQ-033 line_x/line_y SHALL hold their last value between strobes.

Reset
REQ-034 On reset, the block SHALL empty the FIFO (fifo_level=0, cmd_ready=1), enter IDLE, and drive line_strobe=0, line_x=0, line_y=0, blank=1, frame_done=0 and dwell counter=0; this applies mid-segment too, and the in-flight segment SHALL be discarded with no frame_done.

Verification
REQ-035 Reset, line_ready=1, push (100,200,pen=1,last=1) -> line_strobe for one cycle on the edge after acceptance, line_x=100, line_y=200, blank=0; hold line_ready=0 for 50 cycles then 1 -> frame_done for one cycle, next cycle IDLE with blank=1.
REQ-036 Push pen=0 to (10,10) followed by pen=1 to (20,10), line_ready dropping for 5 cycles per segment -> blank=1 through the move plus exactly 8 DWELL cycles, then the second strobe with blank=0.
REQ-037 With line_ready=0, push 17 words at DEPTH=16 -> cmd_ready=0 after 16 accepted, fifo_level=16, 17th word not accepted until a pop occurs.
REQ-038 Push 3 zero-length pen=1 segments, line_ready held 1 -> strobes exactly 3 cycles apart, blank stays 0 throughout.
REQ-039 pause=1 during WAIT of segment 1 with segment 2 queued -> segment 1 completes, no strobe for segment 2 until pause=0, blank=1 while paused in IDLE.
REQ-040 Reset asserted in WAIT with 4 words queued -> next cycle fifo_level=0, blank=1, no frame_done, no strobe.
